// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// The bus carries a req/gnt request phase and an rvalid response phase.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine for the RV32I core.
// It runs one data-memory access at a time over a req/gnt/rvalid bus.
// Load results are lane-selected and sign/zero extended before writeback.
// The pipeline is held through lsu_stall until the access finishes.
//
// state | meaning
// IDLE  | no access outstanding; accept a legal op, flag an illegal one
// REQ   | dmem.req high with captured fields, waiting for gnt
// RSP   | load granted, waiting for rvalid
module load_store_unit #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,  // only 32 is supported
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     mem_op_valid,
  input  logic                     mem_we,
  input  logic [2:0]               mem_funct3,
  input  logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [RF_ADDR_WIDTH-1:0] mem_rd,
  output logic                     lsu_stall,
  output logic                     lsu_exc,
  output logic                     load_wb_valid,
  output logic [RF_ADDR_WIDTH-1:0] load_wb_rd,
  output logic [DATA_WIDTH-1:0]    load_wb_data,
  load_store_unit_if.master        dmem
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t                   state;
  logic [2:0]               f3_q;
  logic [1:0]               off_q;
  logic [RF_ADDR_WIDTH-1:0] rd_q;
  logic                     f3_ok;
  logic                     align_ok;
  logic                     legal;
  logic                     accept;

  // Replicate the low byte/half-word across all lanes so memory can pick it up by byte enable.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd0:    lane_wdata = {4{d[7:0]}};
      2'd1:    lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    lane_be = 4'b0001 << off;
      2'd1:    lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then extend according to funct3.
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> {off, 3'b000};
    case (f3)
      3'd0:    fmt_load = {{24{sh[7]}}, sh[7:0]};
      3'd1:    fmt_load = {{16{sh[15]}}, sh[15:0]};
      3'd4:    fmt_load = {24'h0, sh[7:0]};
      3'd5:    fmt_load = {16'h0, sh[15:0]};
      default: fmt_load = sh;  // LW is word aligned, so sh == d
    endcase
  endfunction

  // Legality of the op offered by EX/MEM: funct3 valid for the direction and natural alignment.
  always_comb begin
    f3_ok    = mem_we ? (mem_funct3 inside {3'd0, 3'd1, 3'd2})
                      : (mem_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    case (mem_funct3[1:0])
      2'd1:    align_ok = ~mem_addr[0];
      2'd2:    align_ok = (mem_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    legal  = f3_ok & align_ok;
    accept = (state == IDLE) & mem_op_valid & legal;
  end

  // Stall covers the accept cycle combinationally, then every cycle an access is outstanding.
  assign lsu_stall = accept | (state != IDLE);

  // Access sequencer with registered bus and writeback outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      f3_q          <= 3'd0;
      off_q         <= 2'd0;
      rd_q          <= '0;
      lsu_exc       <= 1'b0;
      load_wb_valid <= 1'b0;
      load_wb_rd    <= '0;
      load_wb_data  <= '0;
      dmem.req      <= 1'b0;
      dmem.we       <= 1'b0;
      dmem.addr     <= '0;
      dmem.be       <= 4'b0000;
      dmem.wdata    <= '0;
    end else begin
      lsu_exc       <= 1'b0;
      load_wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            f3_q       <= mem_funct3;
            off_q      <= mem_addr[1:0];
            rd_q       <= mem_rd;
            dmem.req   <= 1'b1;
            dmem.we    <= mem_we;
            dmem.addr  <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
            dmem.be    <= lane_be(mem_funct3[1:0], mem_addr[1:0]);
            dmem.wdata <= lane_wdata(mem_funct3[1:0], mem_wdata);
            state      <= REQ;
          end else if (mem_op_valid) begin
            lsu_exc <= 1'b1;
          end
        end
        REQ: begin
          // rvalid arriving here is not ours yet; only gnt advances the access.
          if (dmem.gnt) begin
            dmem.req <= 1'b0;
            state    <= dmem.we ? IDLE : RSP;
          end
        end
        RSP: begin
          if (dmem.rvalid) begin
            load_wb_data  <= fmt_load(f3_q, off_q, dmem.rdata);
            load_wb_rd    <= rd_q;
            load_wb_valid <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized ops checked against
// an arithmetic reference of the load/store rules.
module tb_load_store_unit;

  logic        clk;
  logic        rstn;
  logic        mem_op_valid;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [4:0]  mem_rd;
  logic        lsu_stall;
  logic        lsu_exc;
  logic        load_wb_valid;
  logic [4:0]  load_wb_rd;
  logic [31:0] load_wb_data;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit_if dmem_if ();

  load_store_unit dut (
    .clk           (clk),
    .rstn          (rstn),
    .mem_op_valid  (mem_op_valid),
    .mem_we        (mem_we),
    .mem_funct3    (mem_funct3),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rd        (mem_rd),
    .lsu_stall     (lsu_stall),
    .lsu_exc       (lsu_exc),
    .load_wb_valid (load_wb_valid),
    .load_wb_rd    (load_wb_rd),
    .load_wb_data  (load_wb_data),
    .dmem          (dmem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference rules ----------------
  function automatic int ref_size(input bit [2:0] f3);
    int s;
    s = 1 << f3[1:0];
    return (s > 4) ? 4 : s;
  endfunction

  function automatic bit ref_legal(input bit we, input bit [2:0] f3, input bit [31:0] a);
    bit ok;
    ok = we ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    return ok && ((a % ref_size(f3)) == 0);
  endfunction

  function automatic bit [3:0] ref_be(input bit [2:0] f3, input bit [31:0] a);
    int m;
    m = ((1 << ref_size(f3)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic bit [31:0] ref_wdata(input bit [2:0] f3, input bit [31:0] d);
    case (ref_size(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic bit [31:0] ref_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] d);
    bit [31:0] sh, mask, v;
    int sz;
    sz   = ref_size(f3);
    sh   = d >> (8 * (a % 4));
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
    v    = sh & mask;
    if (f3 < 3'd4 && sz < 4 && ((v >> (8 * sz - 1)) & 32'd1) == 32'd1) v = v | ~mask;
    return v;
  endfunction

  // ---------------- one complete op with cycle-by-cycle checks ----------------
  // Starts on the cycle the op is offered; ends on an IDLE cycle where the next op may be offered.
  task automatic run_op(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                        input bit [4:0] rd, input int gnt_dly, input int rv_dly,
                        input bit [31:0] rdata, input bit junk_rv);
    bit        legal;
    bit [3:0]  e_be;
    bit [31:0] e_wd, e_ld, e_addr;
    legal  = ref_legal(we, f3, a);
    e_be   = ref_be(f3, a);
    e_wd   = ref_wdata(f3, wd);
    e_ld   = ref_load(f3, a, rdata);
    e_addr = a & 32'hFFFF_FFFC;

    mem_op_valid = 1'b1; mem_we = we; mem_funct3 = f3; mem_addr = a; mem_wdata = wd; mem_rd = rd;
    #1;
    n_checks++;
    if (lsu_stall !== legal) begin n_fail++; $display("FAIL accept_stall: lsu_stall=%b want %b (we=%0d f3=%0d addr=%h)", lsu_stall, legal, we, f3, a); end
    @(negedge clk);
    mem_op_valid = 1'b0; mem_we = 1'($urandom); mem_funct3 = 3'($urandom);
    mem_addr = $urandom; mem_wdata = $urandom; mem_rd = 5'($urandom);

    if (!legal) begin
      #1;
      n_checks++;
      if (lsu_exc !== 1'b1) begin n_fail++; $display("FAIL exc_pulse: lsu_exc=%b want 1 (addr=%h f3=%0d)", lsu_exc, a, f3); end
      n_checks++;
      if (dmem_if.req !== 1'b0) begin n_fail++; $display("FAIL exc_no_req: dmem_req=%b want 0", dmem_if.req); end
      n_checks++;
      if (lsu_stall !== 1'b0) begin n_fail++; $display("FAIL exc_no_stall: lsu_stall=%b want 0", lsu_stall); end
      @(negedge clk);
      n_checks++;
      if (lsu_exc !== 1'b0) begin n_fail++; $display("FAIL exc_one_cycle: lsu_exc=%b want 0", lsu_exc); end
      return;
    end

    for (int i = 0; i <= gnt_dly; i++) begin
      dmem_if.gnt    = (i == gnt_dly);
      dmem_if.rvalid = junk_rv ? 1'b1 : 1'($urandom);
      dmem_if.rdata  = $urandom;
      #1;
      n_checks++;
      if (dmem_if.req !== 1'b1) begin n_fail++; $display("FAIL req_high: dmem_req=%b want 1 (cycle %0d)", dmem_if.req, i); end
      n_checks++;
      if (dmem_if.we !== we) begin n_fail++; $display("FAIL req_we: dmem_we=%b want %b", dmem_if.we, we); end
      n_checks++;
      if (dmem_if.addr !== e_addr) begin n_fail++; $display("FAIL req_addr: dmem_addr=%h want %h", dmem_if.addr, e_addr); end
      n_checks++;
      if (dmem_if.be !== e_be) begin n_fail++; $display("FAIL req_be: dmem_be=%b want %b", dmem_if.be, e_be); end
      if (we) begin
        n_checks++;
        if (dmem_if.wdata !== e_wd) begin n_fail++; $display("FAIL req_wdata: dmem_wdata=%h want %h", dmem_if.wdata, e_wd); end
      end
      n_checks++;
      if (lsu_stall !== 1'b1 || load_wb_valid !== 1'b0) begin n_fail++; $display("FAIL req_stall: lsu_stall=%b wb_valid=%b want 1/0", lsu_stall, load_wb_valid); end
      @(negedge clk);
    end
    dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0;
    n_checks++;
    if (dmem_if.req !== 1'b0) begin n_fail++; $display("FAIL req_drop: dmem_req=%b want 0 after gnt", dmem_if.req); end

    if (we) begin
      #1;
      n_checks++;
      if (lsu_stall !== 1'b0 || load_wb_valid !== 1'b0) begin n_fail++; $display("FAIL store_done: lsu_stall=%b wb_valid=%b want 0/0", lsu_stall, load_wb_valid); end
      return;
    end

    for (int i = 0; i <= rv_dly; i++) begin
      dmem_if.rvalid = (i == rv_dly);
      dmem_if.rdata  = (i == rv_dly) ? rdata : $urandom;
      dmem_if.gnt    = 1'($urandom);
      #1;
      n_checks++;
      if (lsu_stall !== 1'b1 || dmem_if.req !== 1'b0 || load_wb_valid !== 1'b0) begin
        n_fail++; $display("FAIL rsp_wait: stall=%b req=%b wb_valid=%b want 1/0/0", lsu_stall, dmem_if.req, load_wb_valid);
      end
      @(negedge clk);
    end
    dmem_if.rvalid = 1'b0; dmem_if.gnt = 1'b0;
    #1;
    n_checks++;
    if (load_wb_valid !== 1'b1) begin n_fail++; $display("FAIL wb_valid: load_wb_valid=%b want 1", load_wb_valid); end
    n_checks++;
    if (load_wb_data !== e_ld) begin n_fail++; $display("FAIL wb_data: load_wb_data=%h want %h (f3=%0d addr=%h rdata=%h)", load_wb_data, e_ld, f3, a, rdata); end
    n_checks++;
    if (load_wb_rd !== rd) begin n_fail++; $display("FAIL wb_rd: load_wb_rd=%0d want %0d", load_wb_rd, rd); end
    n_checks++;
    if (lsu_stall !== 1'b0) begin n_fail++; $display("FAIL wb_stall: lsu_stall=%b want 0 on writeback", lsu_stall); end
    @(negedge clk);
    n_checks++;
    if (load_wb_valid !== 1'b0) begin n_fail++; $display("FAIL wb_pulse: load_wb_valid=%b want 0 after pulse", load_wb_valid); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #2;
    n_checks++;
    if ({lsu_stall, lsu_exc, load_wb_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: stall/exc/wb=%b want 000", {lsu_stall, lsu_exc, load_wb_valid}); end
    n_checks++;
    if (load_wb_rd !== 5'd0 || load_wb_data !== 32'd0) begin n_fail++; $display("FAIL reset_wb: rd=%0d data=%h want 0", load_wb_rd, load_wb_data); end
    n_checks++;
    if ({dmem_if.req, dmem_if.we, dmem_if.be} !== 6'd0 || dmem_if.addr !== 32'd0 || dmem_if.wdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_bus: req=%b we=%b be=%b addr=%h wdata=%h want 0", dmem_if.req, dmem_if.we, dmem_if.be, dmem_if.addr, dmem_if.wdata);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_basic();
    run_op(1'b0, 3'd2, 32'h100, 32'h0, 5'd3, 0, 0, 32'hDEAD_BEEF, 1'b0);
    run_op(1'b0, 3'd2, 32'h104, 32'h0, 5'd0, 1, 2, 32'h0BAD_F00D, 1'b0);  // rd=0 still completes
  endtask

  task automatic test_load_extend();
    run_op(1'b0, 3'd0, 32'h103, 32'h0, 5'd1, 0, 0, 32'h80AA_5511, 1'b0);
    run_op(1'b0, 3'd4, 32'h103, 32'h0, 5'd2, 0, 1, 32'h80AA_5511, 1'b0);
    run_op(1'b0, 3'd1, 32'h102, 32'h0, 5'd4, 1, 0, 32'h80AA_5511, 1'b0);
    run_op(1'b0, 3'd5, 32'h102, 32'h0, 5'd5, 0, 0, 32'h80AA_5511, 1'b0);
  endtask

  task automatic test_store_delayed_gnt();
    run_op(1'b1, 3'd0, 32'h201, 32'h0000_00AB, 5'd9, 3, 0, 32'h0, 1'b0);
    run_op(1'b1, 3'd1, 32'h20A, 32'h1234_CDEF, 5'd9, 2, 0, 32'h0, 1'b0);
  endtask

  task automatic test_illegal();
    run_op(1'b0, 3'd2, 32'h102, 32'h0, 5'd6, 0, 0, 32'h0, 1'b0);
    run_op(1'b1, 3'd1, 32'h005, 32'h0, 5'd6, 0, 0, 32'h0, 1'b0);
    run_op(1'b0, 3'd3, 32'h008, 32'h0, 5'd6, 0, 0, 32'h0, 1'b0);
    run_op(1'b1, 3'd4, 32'h008, 32'h0, 5'd6, 0, 0, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid_access();
    mem_op_valid = 1'b1; mem_we = 1'b0; mem_funct3 = 3'd2; mem_addr = 32'h40; mem_rd = 5'd7;
    @(negedge clk);
    mem_op_valid = 1'b0; dmem_if.gnt = 1'b1;
    @(negedge clk);
    dmem_if.gnt = 1'b0;
    #1;
    n_checks++;
    if (lsu_stall !== 1'b1 || dmem_if.req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rsp: stall=%b req=%b want 1/0", lsu_stall, dmem_if.req); end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({lsu_stall, load_wb_valid, dmem_if.req} !== 3'b000 || dmem_if.addr !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid_clear: stall=%b wb=%b req=%b addr=%h want 0", lsu_stall, load_wb_valid, dmem_if.req, dmem_if.addr);
    end
    dmem_if.rvalid = 1'b1; dmem_if.rdata = 32'h1234_5678;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({load_wb_valid, dmem_if.req, lsu_stall} !== 3'b000) begin
        n_fail++; $display("FAIL rst_late_rvalid: wb=%b req=%b stall=%b want 000 (cycle %0d)", load_wb_valid, dmem_if.req, lsu_stall, i);
      end
    end
    dmem_if.rvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_op(1'b1, 3'd2, 32'h300, 32'hCAFE_0001, 5'd0, 0, 0, 32'h0, 1'b0);
    run_op(1'b0, 3'd2, 32'h304, 32'h0, 5'd11, 0, 0, 32'h7654_3210, 1'b1);
    run_op(1'b1, 3'd0, 32'h307, 32'h0000_005A, 5'd0, 0, 0, 32'h0, 1'b1);
    run_op(1'b1, 3'd1, 32'h30E, 32'h0000_A5C3, 5'd0, 0, 0, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      bit [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;  // bias toward legal addresses
      run_op(1'($urandom), 3'($urandom), a, $urandom, 5'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom));
      for (int k = $urandom_range(0, 2); k > 0; k--) @(negedge clk);
    end
  endtask

  initial begin
    mem_op_valid = 1'b0; mem_we = 1'b0; mem_funct3 = 3'd0;
    mem_addr = 32'd0; mem_wdata = 32'd0; mem_rd = 5'd0;
    dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0; dmem_if.rdata = 32'd0;
    test_reset();
    test_load_basic();
    test_load_extend();
    test_store_delayed_gnt();
    test_illegal();
    test_reset_mid_access();
    @(negedge clk);
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
